multicycle_control_fsm: RTL and testbench

// - Main control sequencer of the multicycle ARM-subset core. Produces the write requests
//   (pcs, regW, memW, flagW) and the cond field consumed by the condition logic.
// - Also produces every datapath mux/enable select.
// - Sits between the instruction register and the condition logic.
// - Paces instruction and data accesses against a memory ready handshake.

---
 rtl/control_pkg.sv | 37 +++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
package control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXECR,
        EXECI,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Commands whose result carries meaningful carry/overflow.
    function automatic logic isArith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation and flag-write decode for the execute and address states.
module alu_decoder
    import control_pkg::*;
(
    input  logic [4:0] funct,
    input  state_t     state,
    output logic [1:0] aluControl,
    output logic [1:0] flagW,
    output logic       cmdValid
);

    always_comb begin
        aluControl = ALU_ADD;
        flagW      = 2'b00;
        cmdValid   = 1'b1;
        case (state)
            EXECR, EXECI: begin
                case (funct[4:1])
                    CMD_ADD:          aluControl = ALU_ADD;
                    CMD_SUB, CMD_CMP: aluControl = ALU_SUB;
                    CMD_AND:          aluControl = ALU_AND;
                    CMD_ORR:          aluControl = ALU_ORR;
                    default:          cmdValid   = 1'b0;
                endcase
                if (cmdValid) begin
                    flagW = {funct[0], funct[0] & isArith(funct[4:1])};
                end
            end
            // U bit selects add or subtract of the offset
            MEMADR:  aluControl = funct[3] ? ALU_ADD : ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer of the multicycle core: state walk, datapath selects,
// write requests, memory pacing with timeout, and retired-instruction count.
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic [3:0]       cond,
    output logic             pcs,
    output logic             regW,
    output logic             memW,
    output logic [1:0]       flagW,
    output logic             nextPC,
    output logic             irWrite,
    output logic             memReq,
    output logic             adrSrc,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluControl,
    output logic [1:0]       immSrc,
    output logic [1:0]       regSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    state_t           state, stateNext;
    logic [TMO_W-1:0] tmoCnt;
    logic             memWait, tmoHit, retire;
    logic [1:0]       op, decFlagW;
    logic [5:0]       funct;
    logic             rd15, isCmp, cmdValid, unusedInstr;

    assign op          = instr[27:26];
    assign funct       = instr[25:20];
    assign rd15        = (instr[15:12] == 4'hF);
    assign isCmp       = (funct[4:1] == CMD_CMP);
    assign unusedInstr = ^{instr[19:16], instr[11:0]};

    assign cond   = instr[31:28];
    assign immSrc = op;
    assign regSrc = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

    alu_decoder uAluDec (
        .funct      (funct[4:0]),
        .state      (state),
        .aluControl (aluControl),
        .flagW      (decFlagW),
        .cmdValid   (cmdValid)
    );

    // Timeout only advances while a memory access is outstanding.
    assign memWait = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
    assign tmoHit  = TMO_EN && memWait && (tmoCnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmoCnt  <= '0;
            retired <= '0;
        end else begin
            tmoCnt <= (memWait && !tmoHit) ? tmoCnt + TMO_W'(1) : '0;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        pcs       = 1'b0;
        regW      = 1'b0;
        memW      = 1'b0;
        flagW     = decFlagW;
        nextPC    = 1'b0;
        irWrite   = 1'b0;
        memReq    = 1'b0;
        adrSrc    = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        resultSrc = 2'b00;
        illegal   = 1'b0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                memReq    = 1'b1;
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                if (mem_ready) begin
                    irWrite   = 1'b1;
                    nextPC    = 1'b1;
                    stateNext = DECODE;
                end else if (tmoHit) begin
                    illegal = 1'b1;
                end
            end
            DECODE: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                case (op)
                    OP_DP:   stateNext = funct[5] ? EXECI : EXECR;
                    OP_MEM:  stateNext = MEMADR;
                    OP_BR:   stateNext = BRANCH;
                    default: begin
                        illegal   = 1'b1;
                        stateNext = FETCH;
                    end
                endcase
            end
            EXECR, EXECI: begin
                aluSrcB = (state == EXECI) ? 2'b01 : 2'b00;
                if (cmdValid) begin
                    stateNext = ALUWB;
                end else begin
                    illegal   = 1'b1;
                    stateNext = FETCH;
                end
            end
            ALUWB: begin
                regW      = !isCmp;
                pcs       = !isCmp && rd15;
                retire    = 1'b1;
                stateNext = FETCH;
            end
            MEMADR: begin
                aluSrcB   = 2'b01;
                stateNext = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (mem_ready) begin
                    stateNext = MEMWB;
                end else if (tmoHit) begin
                    illegal   = 1'b1;
                    stateNext = FETCH;
                end
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regW      = 1'b1;
                pcs       = rd15;
                retire    = 1'b1;
                stateNext = FETCH;
            end
            MEMWR: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (mem_ready) begin
                    memW      = 1'b1;
                    retire    = 1'b1;
                    stateNext = FETCH;
                end else if (tmoHit) begin
                    illegal   = 1'b1;
                    stateNext = FETCH;
                end
            end
            BRANCH: begin
                aluSrcB   = 2'b01;
                resultSrc = 2'b10;
                pcs       = 1'b1;
                regW      = funct[4];
                retire    = 1'b1;
                stateNext = FETCH;
            end
            default: stateNext = FETCH;
        endcase
        // Reset abandons the instruction: no request may escape this cycle.
        if (!rst) begin
            pcs       = 1'b0;
            regW      = 1'b0;
            memW      = 1'b0;
            flagW     = 2'b00;
            nextPC    = 1'b0;
            irWrite   = 1'b0;
            memReq    = 1'b0;
            illegal   = 1'b0;
            retire    = 1'b0;
            stateNext = FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: directed reset/timeout/abort checks, then random instruction
// traffic whose write events are predicted from the instruction rules.
module tb_multicycle_control_fsm;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 4;
    localparam int N = 200;

    logic          clk = 1'b0;
    logic          rst, mem_ready;
    logic [31:0]   instr;
    logic [3:0]    cond;
    logic          pcs, regW, memW, nextPC, irWrite, memReq, adrSrc, aluSrcA, illegal;
    logic [1:0]    flagW, aluSrcB, resultSrc, aluControl, immSrc, regSrc;
    logic [CW-1:0] retired;

    multicycle_control_fsm #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .cond(cond),
        .pcs(pcs), .regW(regW), .memW(memW), .flagW(flagW), .nextPC(nextPC),
        .irWrite(irWrite), .memReq(memReq), .adrSrc(adrSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .resultSrc(resultSrc), .aluControl(aluControl),
        .immSrc(immSrc), .regSrc(regSrc), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pcs;
        logic          regW;
        logic          memW;
        logic [1:0]    flagW;
        logic          illegal;
        logic [1:0]    alu;
        logic [3:0]    cond;
        logic [1:0]    regSrc;
        logic [CW-1:0] ret;
    } ev_t;

    ev_t           expQ[$];
    int unsigned   waitQ[$];
    logic [31:0]   words [N];
    logic [3:0]    legalCmds [5] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA};
    logic [CW-1:0] modelRet;
    int            errors = 0;
    int            checks = 0;
    bit            monEn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference: the ordered write events one instruction must produce.
    task automatic predict(input logic [31:0] w);
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] cmd;
        ev_t        e, x;
        op  = w[27:26];
        f   = w[25:20];
        cmd = f[4:1];
        e   = '0;
        e.cond   = w[31:28];
        e.regSrc = {(op == 2'd1) && !f[0], op == 2'd2};
        e.ret    = modelRet;
        case (op)
            2'd0: begin
                if (!(cmd inside {4'h4, 4'h2, 4'h0, 4'hC, 4'hA})) begin
                    x = e; x.illegal = 1'b1; expQ.push_back(x);
                end else begin
                    if (f[0]) begin
                        x = e;
                        x.flagW = {1'b1, cmd inside {4'h4, 4'h2, 4'hA}};
                        x.alu = (cmd == 4'h4) ? 2'd0 : (cmd == 4'h0) ? 2'd2 :
                                (cmd == 4'hC) ? 2'd3 : 2'd1;
                        expQ.push_back(x);
                    end
                    if (cmd != 4'hA) begin
                        x = e; x.regW = 1'b1; x.pcs = (w[15:12] == 4'hF); expQ.push_back(x);
                    end
                    modelRet = modelRet + 1'b1;
                end
            end
            2'd1: begin
                x = e;
                if (f[0]) begin x.regW = 1'b1; x.pcs = (w[15:12] == 4'hF); end
                else x.memW = 1'b1;
                expQ.push_back(x);
                modelRet = modelRet + 1'b1;
            end
            2'd2: begin
                x = e; x.pcs = 1'b1; x.regW = f[4]; expQ.push_back(x);
                modelRet = modelRet + 1'b1;
            end
            default: begin
                x = e; x.illegal = 1'b1; expQ.push_back(x);
            end
        endcase
    endtask

    initial begin
        int  k, accCnt, evNum;
        bit  lastFetched, done;
        logic [1:0] op;
        logic [31:0] w;

        fork
            forever begin
                ev_t got, want;
                @(negedge clk);
                #2;
                if (monEn && rst === 1'b1 && (pcs | regW | memW | (|flagW) | illegal)) begin
                    got = '{pcs, regW, memW, flagW, illegal, aluControl, cond, regSrc, retired};
                    checks++;
                    evNum++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL event %0d: unexpected %h, none expected", evNum, got);
                    end else begin
                        want = expQ.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL event %0d: got %h expected %h", evNum, got, want);
                        end
                    end
                end
            end
        join_none

        evNum = 0;
        rst = 1'b0; mem_ready = 1'b1; instr = 32'hE0921003;
        repeat (2) begin
            @(negedge clk);
            chk("reset writes", {pcs, regW, memW, flagW, irWrite, nextPC, memReq}, 0);
            chk("reset retired", retired, 0);
        end

        rst = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (c == 1) chk("fetch memReq/adrSrc", {memReq, adrSrc}, 2'b10);
            chk("timeout illegal", illegal, c == 4);
        end
        chk("timeout retired", retired, 0);

        // Reset landing in MEMWR must suppress the store.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; mem_ready = 1'b1; instr = 32'hE5801000;
        #1 chk("fetch irWrite", {irWrite, nextPC}, 2'b11);
        @(negedge clk); mem_ready = 1'b0;
        #1 chk("store regSrc", regSrc, 2'b10);
        @(negedge clk);
        #1 chk("memadr aluControl", aluControl, 2'b00);
        @(negedge clk);
        #1 chk("memwr waiting", {memReq, adrSrc, memW}, 3'b110);
        rst = 1'b0; mem_ready = 1'b1;
        #1 chk("memwr under reset", {memW, memReq}, 2'b00);
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
        #1 chk("after abort fetch", {memReq, adrSrc, retired}, {2'b10, CW'(0)});

        words[0] = 32'hE0921003;
        words[1] = 32'hE590F004;
        words[2] = 32'hE5801000;
        words[3] = 32'hEB000002;
        words[4] = 32'hEC000000;
        for (int i = 5; i < N; i++) begin
            int sel;
            w = $urandom;
            sel = $urandom_range(0, 9);
            op = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            w[27:26] = op;
            if (op == 2'd0 && $urandom_range(0, 4) != 0) w[24:21] = legalCmds[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
            words[i] = w;
        end
        for (int i = 0; i < N; i++) begin
            waitQ.push_back((i < 2) ? 0 : $urandom_range(0, MT - 1));
            w = words[i];
            if (w[27:26] == 2'd1) waitQ.push_back((i == 1) ? 3 : $urandom_range(0, MT - 1));
        end

        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; monEn = 1'b1;
        modelRet = '0; k = 0; accCnt = 0; lastFetched = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (memReq) begin
                if (lastFetched && !adrSrc) begin
                    done = 1'b1;
                    mem_ready = 1'b0;
                end else if (waitQ.size() == 0) begin
                    mem_ready = 1'b0;
                end else if (accCnt == int'(waitQ[0])) begin
                    mem_ready = 1'b1;
                    accCnt = 0;
                    void'(waitQ.pop_front());
                    if (!adrSrc) begin
                        instr = words[k];
                        predict(words[k]);
                        k++;
                        if (k == N) lastFetched = 1'b1;
                    end
                end else begin
                    mem_ready = 1'b0;
                    accCnt++;
                end
            end else begin
                mem_ready = 1'($urandom);
            end
        end
        #3;
        chk("random run completed", done, 1);
        chk("final retired", retired, modelRet);
        chk("events drained", expQ.size(), 0);
        monEn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
